// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster geometry, sync polarity and coordinate type for the VGA scan stage.
// The scroll-reverse feature elsewhere is enabled by the VGA_SCROLL_REVERSE_EN macro.
package vga_timing_pkg;

   localparam int H_DISPLAY = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = 800;

   localparam int V_DISPLAY = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = 525;

   localparam logic SYNC_ACTIVE = 1'b0;

   typedef logic [9:0] coord_t;

endpackage

// File: rtl/scroll_offset_acc.sv
// Scroll offset accumulator: synchronizes the asynchronous control pins and steps the offset
// modulo OFFSET_MOD on each enable. Decrement stepping exists only with VGA_SCROLL_REVERSE_EN.
module scroll_offset_acc
   import vga_timing_pkg::*;
#(
   parameter int OFFSET_MOD = 640,
   parameter int SPEED_W    = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [SPEED_W-1:0] speed,
   input  logic               pause,
   input  logic               dir,
   output coord_t             offset
);

   localparam logic [10:0] MOD_W = 11'(OFFSET_MOD);

   logic [SPEED_W-1:0] speed_meta;
   logic [SPEED_W-1:0] speed_sync;
   logic               pause_meta;
   logic               pause_sync;
   logic [10:0]        cur;
   logic [10:0]        step;
   logic [10:0]        sum;
   logic [10:0]        next_wide;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         speed_meta <= '0;
         speed_sync <= '0;
         pause_meta <= 1'b0;
         pause_sync <= 1'b0;
      end else begin
         speed_meta <= speed;
         speed_sync <= speed_meta;
         pause_meta <= pause;
         pause_sync <= pause_meta;
      end
   end

`ifdef VGA_SCROLL_REVERSE_EN
   logic dir_meta;
   logic dir_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_meta <= 1'b0;
         dir_sync <= 1'b0;
      end else begin
         dir_meta <= dir;
         dir_sync <= dir_meta;
      end
   end
`else
   logic unused_dir;
   assign unused_dir = dir;
`endif

   // 11-bit arithmetic keeps offset+speed and offset+MOD-speed from overflowing.
   assign cur  = {1'b0, offset};
   assign step = 11'(speed_sync);
   assign sum  = cur + step;

   always_comb begin
      next_wide = (sum >= MOD_W) ? sum - MOD_W : sum;
`ifdef VGA_SCROLL_REVERSE_EN
      if (dir_sync) begin
         next_wide = (cur < step) ? cur + MOD_W - step : cur - step;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         offset <= '0;
      end else if (en && !pause_sync) begin
         offset <= 10'(next_wide);
      end
   end

endmodule

// File: rtl/vga_scan_timing.sv
// VGA raster timing generator: registered pixel counters, syncs, display enable, vblank tick
// and a per-frame scroll offset. Optional reverse scrolling via VGA_SCROLL_REVERSE_EN.
module vga_scan_timing
   import vga_timing_pkg::*;
#(
   parameter int OFFSET_MOD = 640,
   parameter int SPEED_W    = 3,
   parameter int H_ACTIVE   = H_DISPLAY,
   parameter int H_FP       = H_FRONT,
   parameter int H_SW       = H_SYNC,
   parameter int H_BP       = H_BACK,
   parameter int V_ACTIVE   = V_DISPLAY,
   parameter int V_FP       = V_FRONT,
   parameter int V_SW       = V_SYNC,
   parameter int V_BP       = V_BACK
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SPEED_W-1:0] speed,
   input  logic               pause,
   input  logic               dir,
   output coord_t             pix_x,
   output coord_t             pix_y,
   output logic               hsync,
   output logic               vsync,
   output logic               display_on,
   output coord_t             x_offset,
   output logic               frame_tick
);

   localparam coord_t H_LAST   = coord_t'(H_ACTIVE + H_FP + H_SW + H_BP - 1);
   localparam coord_t V_LAST   = coord_t'(V_ACTIVE + V_FP + V_SW + V_BP - 1);
   localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
   localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
   localparam coord_t HS_BEGIN = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SW);
   localparam coord_t VS_BEGIN = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SW);

   coord_t x_next;
   coord_t y_next;
   logic   vblank_start;

   always_comb begin
      x_next = (pix_x == H_LAST) ? '0 : pix_x + 10'd1;
      y_next = pix_y;
      if (pix_x == H_LAST) begin
         y_next = (pix_y == V_LAST) ? '0 : pix_y + 10'd1;
      end
   end

   assign vblank_start = (x_next == '0) && (y_next == V_VIS);

   // Decoding from the next counter values keeps every output aligned with pix_x/pix_y.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_x      <= H_LAST;
         pix_y      <= V_LAST;
         hsync      <= ~SYNC_ACTIVE;
         vsync      <= ~SYNC_ACTIVE;
         display_on <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         pix_x      <= x_next;
         pix_y      <= y_next;
         hsync      <= (x_next >= HS_BEGIN && x_next < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync      <= (y_next >= VS_BEGIN && y_next < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         display_on <= (x_next < H_VIS) && (y_next < V_VIS);
         frame_tick <= vblank_start;
      end
   end

   scroll_offset_acc #(
      .OFFSET_MOD (OFFSET_MOD),
      .SPEED_W    (SPEED_W)
   ) u_scroll (
      .clk    (clk),
      .rst    (rst),
      .en     (vblank_start),
      .speed  (speed),
      .pause  (pause),
      .dir    (dir),
      .offset (x_offset)
   );

endmodule
